// File: rtl/axil_c2p_cmd_bridge_if.sv
// rtl/axil_c2p_cmd_bridge_if.sv - AXI4-Lite slave bus plus per-channel output streams
interface axil_c2p_cmd_bridge_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]        s_awaddr;
    logic                     s_awvalid;
    logic                     s_awready;
    logic [31:0]              s_wdata;
    logic                     s_wvalid;
    logic                     s_wready;
    logic [1:0]               s_bresp;
    logic                     s_bvalid;
    logic                     s_bready;
    logic [ADDR_W-1:0]        s_araddr;
    logic                     s_arvalid;
    logic                     s_arready;
    logic [31:0]              s_rdata;
    logic [1:0]               s_rresp;
    logic                     s_rvalid;
    logic                     s_rready;
    logic [NUM_CH*DATA_W-1:0] m_tdata;
    logic [NUM_CH-1:0]        m_tvalid;
    logic [NUM_CH-1:0]        m_tlast;
    logic [NUM_CH-1:0]        m_tready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, m_tready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, m_tready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axil_c2p_cmd_bridge.sv
// rtl/axil_c2p_cmd_bridge.sv - AXI4-Lite buffered multi-channel command/stream bridge
module axil_c2p_cmd_bridge #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                 aclk,
    input  logic                 reset,
    axil_c2p_cmd_bridge_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int CHW = ADDR_W - 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state_q;
    r_state_t          r_state_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;
    logic [1:0]        bresp_d;
    logic [1:0]        rresp_d;
    logic [31:0]       rdata_d;

    logic [DATA_W-1:0] mem_q   [NUM_CH][DEPTH];
    logic [PW-1:0]     wptr_q  [NUM_CH];
    logic [PW-1:0]     rptr_q  [NUM_CH];
    logic [LW-1:0]     level_q [NUM_CH];
    logic [LW-1:0]     rem_q   [NUM_CH];
    logic [31:0]       count_q [NUM_CH];
    logic [NUM_CH-1:0] drain_q;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] hit;

    logic [CHW-1:0]    w_ch;
    logic [3:0]        w_off;
    logic [CHW-1:0]    r_ch;
    logic [3:0]        r_off;
    logic              w_acc;
    logic              r_acc;

    assign w_ch  = bus.s_awaddr[ADDR_W-1:4];
    assign w_off = bus.s_awaddr[3:0];
    assign r_ch  = bus.s_araddr[ADDR_W-1:4];
    assign r_off = bus.s_araddr[3:0];

    // Address and data are only taken together, so a write is a single-cycle event
    assign w_acc         = !reset && (w_state_q == W_IDLE) && bus.s_awvalid && bus.s_wvalid;
    assign r_acc         = !reset && (r_state_q == R_IDLE);
    assign bus.s_awready = w_acc;
    assign bus.s_wready  = w_acc;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = bresp_q;
    assign bus.s_arready = r_acc;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rresp   = rresp_q;
    assign bus.s_rdata   = rdata_q;

    // Per-channel flags and write-target decode
    always_comb begin
        full  = '0;
        empty = '0;
        hit   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]  = (level_q[c] == LW'(DEPTH));
            empty[c] = (level_q[c] == '0);
            hit[c]   = w_acc && (w_ch == CHW'(c));
        end
    end

    // Write response: unmatched channel is DECERR, busy/full targets reject
    always_comb begin
        bresp_d = RESP_DECERR;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == CHW'(c)) begin
                bresp_d = RESP_OKAY;
                case (w_off)
                    4'h0:    if (full[c] || drain_q[c]) bresp_d = RESP_SLVERR;
                    4'h4:    if (drain_q[c]) bresp_d = RESP_SLVERR;
                    default: ;
                endcase
            end
        end
    end

    // Read data mux: STATUS and COUNT per channel, everything else reads zero
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CHW'(c)) begin
                rresp_d = RESP_OKAY;
                case (r_off)
                    4'h8:    rdata_d = {13'd0, drain_q[c], empty[c], full[c], 16'(level_q[c])};
                    4'hC:    rdata_d = count_q[c];
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    // Stream outputs come straight from drain state and FIFO head so they cannot retract
    always_comb begin
        bus.m_tdata  = '0;
        bus.m_tvalid = '0;
        bus.m_tlast  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.m_tvalid[c] = drain_q[c];
            bus.m_tlast[c]  = drain_q[c] && (rem_q[c] == LW'(1));
            bus.m_tdata[c*DATA_W +: DATA_W] = drain_q[c] ? mem_q[c][rptr_q[c]] : '0;
        end
    end

    // Write FSM: accept, then hold the response until the master takes it
    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (w_acc) begin
                    w_state_q <= W_RESP;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= bresp_d;
                end
                W_RESP: if (bus.s_bready) begin
                    w_state_q <= W_IDLE;
                    bvalid_q  <= 1'b0;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: data is captured at accept and held until the master takes it
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (bus.s_arvalid) begin
                    r_state_q <= R_DATA;
                    rvalid_q  <= 1'b1;
                    rresp_q   <= rresp_d;
                    rdata_q   <= rdata_d;
                end
                R_DATA: if (bus.s_rready) begin
                    r_state_q <= R_IDLE;
                    rvalid_q  <= 1'b0;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Channel FSMs: IDLE takes pushes/commands, DRAIN pops the latched burst and ignores writes
    always_ff @(posedge aclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                level_q[c] <= '0;
                rem_q[c]   <= '0;
                count_q[c] <= '0;
                drain_q[c] <= 1'b0;
            end else if (drain_q[c]) begin
                if (bus.m_tready[c]) begin
                    rptr_q[c]  <= rptr_q[c] + 1'b1;
                    level_q[c] <= level_q[c] - 1'b1;
                    rem_q[c]   <= rem_q[c] - 1'b1;
                    count_q[c] <= count_q[c] + 32'd1;
                    if (rem_q[c] == LW'(1)) drain_q[c] <= 1'b0;
                end
            end else if (hit[c]) begin
                case (w_off)
                    4'h0: if (!full[c]) begin
                        mem_q[c][wptr_q[c]] <= bus.s_wdata[DATA_W-1:0];
                        wptr_q[c]           <= wptr_q[c] + 1'b1;
                        level_q[c]          <= level_q[c] + 1'b1;
                    end
                    4'h4: if (bus.s_wdata[1]) begin
                        wptr_q[c]  <= '0;
                        rptr_q[c]  <= '0;
                        level_q[c] <= '0;
                    end else if (bus.s_wdata[0] && !empty[c]) begin
                        drain_q[c] <= 1'b1;
                        rem_q[c]   <= level_q[c];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axil_c2p_cmd_bridge.sv
// tb/tb_axil_c2p_cmd_bridge.sv - directed self-checking bench for axil_c2p_cmd_bridge
module tb_axil_c2p_cmd_bridge;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;

    logic aclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_viol = 0;

    logic [15:0]       pat [NUM_CH];
    logic [32:0]       beats [NUM_CH][$];
    logic [NUM_CH-1:0] prev_stall = '0;
    logic [31:0]       prev_data [NUM_CH];

    axil_c2p_cmd_bridge_if #(.NUM_CH(NUM_CH), .DATA_W(32), .ADDR_W(8)) bus();

    axil_c2p_cmd_bridge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(32), .ADDR_W(8)) dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 aclk = ~aclk;

    // Per-channel ready patterns, stepped just after each rising edge
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            for (int c = 0; c < NUM_CH; c++) bus.m_tready[c] = pat[c][cyc % 16];
        end
    end

    // Beat recorder and stall-stability watcher
    initial begin
        forever begin
            @(negedge aclk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.m_tvalid[c] && bus.m_tready[c])
                    beats[c].push_back({bus.m_tlast[c], bus.m_tdata[c*32 +: 32]});
                if (prev_stall[c] && (!bus.m_tvalid[c] || bus.m_tdata[c*32 +: 32] !== prev_data[c]))
                    stall_viol++;
                prev_stall[c] = bus.m_tvalid[c] && !bus.m_tready[c];
                prev_data[c]  = bus.m_tdata[c*32 +: 32];
            end
        end
    end

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        @(negedge aclk);
        bus.s_awaddr = addr; bus.s_wdata = data; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        #1;
        while (!(bus.s_awready && bus.s_wready) && t < 20) begin @(negedge aclk); #1; t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL aw_timeout addr=%h got=no awready required=awready", addr);
            bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; resp = 2'bxx;
            return;
        end
        @(posedge aclk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        t = 0;
        @(negedge aclk);
        while (!bus.s_bvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL b_timeout addr=%h got=no bvalid required=bvalid", addr);
            resp = 2'bxx;
        end else resp = bus.s_bresp;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        @(negedge aclk);
        bus.s_araddr = addr; bus.s_arvalid = 1'b1;
        #1;
        while (!bus.s_arready && t < 20) begin @(negedge aclk); #1; t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h got=no arready required=arready", addr);
            bus.s_arvalid = 1'b0; data = 'x; resp = 2'bxx;
            return;
        end
        @(posedge aclk); #1;
        bus.s_arvalid = 1'b0;
        t = 0;
        @(negedge aclk);
        while (!bus.s_rvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL r_timeout addr=%h got=no rvalid required=rvalid", addr);
            data = 'x; resp = 2'bxx;
        end else begin
            data = bus.s_rdata; resp = bus.s_rresp;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        reset = 1'b1;
        bus.s_awaddr = 8'h0C; bus.s_wdata = '0; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b000) begin
            errors++; $display("FAIL rst_ready got=%b required=000", {bus.s_awready, bus.s_wready, bus.s_arready});
        end
        checks++;
        if ({bus.s_bvalid, bus.s_rvalid, bus.s_bresp, bus.s_rresp} !== 6'd0) begin
            errors++; $display("FAIL rst_resp got=%b required=0", {bus.s_bvalid, bus.s_rvalid, bus.s_bresp, bus.s_rresp});
        end
        checks++;
        if (bus.s_rdata !== 32'd0) begin
            errors++; $display("FAIL rst_rdata got=%h required=0", bus.s_rdata);
        end
        checks++;
        if ({bus.m_tvalid, bus.m_tlast, bus.m_tdata} !== '0) begin
            errors++; $display("FAIL rst_stream got=%b/%b/%h required=0", bus.m_tvalid, bus.m_tlast, bus.m_tdata);
        end
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({bus.s_awready, bus.s_arready} !== 2'b11) begin
            errors++; $display("FAIL rel_ready got=%b required=11", {bus.s_awready, bus.s_arready});
        end
        @(posedge aclk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if ({bus.s_bvalid, bus.s_bresp} !== 3'b100) begin
            errors++; $display("FAIL rel_bresp got=%b required=100", {bus.s_bvalid, bus.s_bresp});
        end
        axi_read(8'h08, d, r);
        checks++;
        if ({r, d} !== {2'b00, 32'h0002_0000}) begin
            errors++; $display("FAIL rst_status got=%h/%h required=0/00020000", r, d);
        end
        axi_read(8'h0C, d, r);
        checks++;
        if ({r, d} !== 34'd0) begin
            errors++; $display("FAIL rst_count got=%h/%h required=0/0", r, d);
        end
    endtask

    task automatic test_basic_burst;
        logic [31:0] d;
        logic [1:0]  r;
        pat[0] = 16'hFFFF;
        beats[0].delete();
        for (int i = 0; i < 3; i++) begin
            axi_write(8'h00, 32'(6 + i), r);
            checks++;
            if (r !== 2'b00) begin errors++; $display("FAIL t1_push_bresp got=%b required=00", r); end
        end
        axi_write(8'h04, 32'd1, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL t1_start_bresp got=%b required=00", r); end
        repeat (8) @(negedge aclk);
        checks++;
        if (beats[0].size() !== 3) begin errors++; $display("FAIL t1_beats got=%0d required=3", beats[0].size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < beats[0].size()) begin
                checks++;
                if (beats[0][i] !== {i == 2, 32'(6 + i)}) begin
                    errors++; $display("FAIL t1_beat%0d got=%h required=%h", i, beats[0][i], {i == 2, 32'(6 + i)});
                end
            end
        end
        axi_read(8'h08, d, r);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL t1_status got=%h required=00020000", d); end
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL t1_count got=%h required=3", d); end
    endtask

    task automatic test_full;
        logic [31:0] d;
        logic [1:0]  r;
        int          nbad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            axi_write(8'h10, 32'h1000 + 32'(i), r);
            if (r !== 2'b00) nbad++;
        end
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL t2_fill_bresp got=%0d bad required=0", nbad); end
        axi_write(8'h10, 32'h1FFF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL t2_overflow_bresp got=%b required=10", r); end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== 32'h0001_0010) begin errors++; $display("FAIL t2_status got=%h required=00010010", d); end
        axi_write(8'h14, 32'd2, r);
        axi_read(8'h18, d, r);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL t2_flushed got=%h required=00020000", d); end
    endtask

    task automatic test_stall;
        logic [31:0] d;
        logic [1:0]  r;
        pat[2] = 16'h9999;
        beats[2].delete();
        for (int i = 0; i < 5; i++) axi_write(8'h20, 32'hA0 + 32'(i), r);
        stall_viol = 0;
        axi_write(8'h24, 32'd1, r);
        axi_write(8'h20, 32'hEE, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL t3_data_in_drain got=%b required=10", r); end
        axi_write(8'h24, 32'd1, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL t3_start_in_drain got=%b required=10", r); end
        repeat (30) @(negedge aclk);
        checks++;
        if (beats[2].size() !== 5) begin errors++; $display("FAIL t3_beats got=%0d required=5", beats[2].size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < beats[2].size()) begin
                checks++;
                if (beats[2][i] !== {i == 4, 32'hA0 + 32'(i)}) begin
                    errors++; $display("FAIL t3_beat%0d got=%h required=%h", i, beats[2][i], {i == 4, 32'hA0 + 32'(i)});
                end
            end
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL t3_stall_stable got=%0d required=0", stall_viol); end
        axi_read(8'h2C, d, r);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL t3_count got=%h required=5", d); end
        axi_read(8'h28, d, r);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL t3_status got=%h required=00020000", d); end
        pat[2] = 16'h0000;
    endtask

    task automatic test_two_channels;
        logic [31:0] d;
        logic [1:0]  r;
        pat[0] = 16'hFFFF;
        pat[3] = 16'hAAAA;
        beats[0].delete();
        beats[3].delete();
        for (int i = 0; i < 3; i++) axi_write(8'h00, 32'h100 + 32'(i), r);
        for (int i = 0; i < 5; i++) axi_write(8'h30, 32'h300 + 32'(i), r);
        axi_write(8'h04, 32'd1, r);
        axi_write(8'h34, 32'd1, r);
        repeat (30) @(negedge aclk);
        checks++;
        if (beats[0].size() !== 3 || beats[3].size() !== 5) begin
            errors++; $display("FAIL t4_beats got=%0d/%0d required=3/5", beats[0].size(), beats[3].size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 3 && i < beats[0].size()) begin
                checks++;
                if (beats[0][i] !== {i == 2, 32'h100 + 32'(i)}) begin
                    errors++; $display("FAIL t4_ch0_beat%0d got=%h required=%h", i, beats[0][i], {i == 2, 32'h100 + 32'(i)});
                end
            end
            if (i < beats[3].size()) begin
                checks++;
                if (beats[3][i] !== {i == 4, 32'h300 + 32'(i)}) begin
                    errors++; $display("FAIL t4_ch3_beat%0d got=%h required=%h", i, beats[3][i], {i == 4, 32'h300 + 32'(i)});
                end
            end
        end
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL t4_count_ch0 got=%h required=6", d); end
        axi_read(8'h3C, d, r);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL t4_count_ch3 got=%h required=5", d); end
    endtask

    task automatic test_decode_flush;
        logic [31:0] d;
        logic [1:0]  r;
        pat[1] = 16'hFFFF;
        beats[1].delete();
        axi_write(8'h40, 32'h55, r);
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL t5_wr_decerr got=%b required=11", r); end
        axi_read(8'h48, d, r);
        checks++;
        if ({r, d} !== {2'b11, 32'd0}) begin errors++; $display("FAIL t5_rd_decerr got=%b/%h required=11/0", r, d); end
        axi_read(8'h00, d, r);
        checks++;
        if ({r, d} !== 34'd0) begin errors++; $display("FAIL t5_rd_unmapped got=%b/%h required=00/0", r, d); end
        axi_write(8'h10, 32'h77, r);
        axi_write(8'h10, 32'h78, r);
        axi_write(8'h14, 32'd3, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL t5_ctrl3_bresp got=%b required=00", r); end
        repeat (10) @(negedge aclk);
        checks++;
        if (beats[1].size() !== 0) begin errors++; $display("FAIL t5_no_burst got=%0d required=0", beats[1].size()); end
        axi_read(8'h18, d, r);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL t5_status got=%h required=00020000", d); end
        axi_read(8'h1C, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL t5_count got=%h required=0", d); end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] d;
        logic [1:0]  r;
        int          n = 0;
        int          t = 0;
        pat[2] = 16'h0000;
        for (int i = 0; i < 5; i++) axi_write(8'h20, 32'hC0 + 32'(i), r);
        axi_write(8'h24, 32'd1, r);
        @(negedge aclk);
        pat[2] = 16'hFFFF;
        while (n < 2 && t < 50) begin
            @(negedge aclk);
            if (bus.m_tvalid[2] && bus.m_tready[2]) n++;
            t++;
        end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL t6_two_beats got=%0d required=2", n); end
        @(posedge aclk); #1;
        reset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (bus.m_tvalid !== '0) begin errors++; $display("FAIL t6_tvalid got=%b required=0", bus.m_tvalid); end
        @(posedge aclk); #1;
        reset = 1'b0;
        axi_read(8'h28, d, r);
        checks++;
        if (d !== 32'h0002_0000) begin errors++; $display("FAIL t6_status got=%h required=00020000", d); end
        axi_read(8'h2C, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL t6_count_ch2 got=%h required=0", d); end
        axi_read(8'h0C, d, r);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL t6_count_ch0 got=%h required=0", d); end
        pat[2] = 16'h0000;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) pat[c] = 16'h0000;
        test_reset();
        test_basic_burst();
        test_full();
        test_stall();
        test_two_channels();
        test_decode_flush();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
